// File: rtl/mem_bus_controller.sv
// Sequencer between the CPU load/store path and a word-wide asynchronous-handshake RAM.
// Handles byte/half/word accesses, read-modify-write for sub-word stores, misalignment and MOC timeout.
module mem_bus_controller #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_signed,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  output logic              cpu_err,
  output logic              mem_enable,
  output logic              mem_mov,
  output logic              mem_rw,
  output logic [7:0]        mem_address,
  output logic [31:0]       mem_datain,
  input  logic [31:0]       mem_dataout,
  input  logic              mem_moc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_WAIT, MERGE, WR_SETUP, WR_WAIT, DONE, ERR
  } state_t;

  state_t            state, state_next;
  logic              rw_r;
  logic [1:0]        size_r;
  logic              signed_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       data_word;
  logic [CNT_W-1:0]  wait_cnt;
  logic              misaligned;
  logic              timeout_hit;

  // Big-endian lane selection: byte 0 is bits 31:24, halfword 0 is bits 31:16.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (size)
      2'b00:   extract = {{24{sgn & b[7]}}, b};
      2'b01:   extract = {{16{sgn & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    if (size == 2'b00) begin
      case (off)
        2'd0:    r[31:24] = wd[7:0];
        2'd1:    r[23:16] = wd[7:0];
        2'd2:    r[15:8]  = wd[7:0];
        default: r[7:0]   = wd[7:0];
      endcase
    end else if (off[1]) begin
      r[15:0] = wd[15:0];
    end else begin
      r[31:16] = wd[15:0];
    end
    return r;
  endfunction

  assign misaligned  = (cpu_size == 2'b11) ||
                       (cpu_size == 2'b01 && cpu_addr[0]) ||
                       (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00);
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_enable = 1'b0;
    mem_mov    = 1'b0;
    mem_rw     = 1'b0;
    cpu_ready  = 1'b0;
    cpu_err    = 1'b0;
    cpu_busy   = (state != IDLE);
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (misaligned)                          state_next = ERR;
          else if (cpu_rw || cpu_size != 2'b10)    state_next = RD_SETUP;
          else                                     state_next = WR_SETUP;
        end
      end
      RD_SETUP: begin
        mem_enable = 1'b1;
        mem_rw     = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        mem_enable = 1'b1;
        mem_rw     = 1'b1;
        mem_mov    = 1'b1;
        if (mem_moc)          state_next = rw_r ? DONE : MERGE;
        else if (timeout_hit) state_next = ERR;
      end
      MERGE: begin
        mem_enable = 1'b1;
        state_next = WR_SETUP;
      end
      WR_SETUP: begin
        mem_enable = 1'b1;
        state_next = WR_WAIT;
      end
      WR_WAIT: begin
        mem_enable = 1'b1;
        mem_mov    = 1'b1;
        if (mem_moc)          state_next = DONE;
        else if (timeout_hit) state_next = ERR;
      end
      DONE: begin
        cpu_ready  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        cpu_ready  = 1'b1;
        cpu_err    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign mem_address = 8'(addr_r[ADDR_W-1:2]);
  assign mem_datain  = data_word;

  // data_word doubles as the write data and the read-back word being merged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_r      <= 1'b0;
      size_r    <= 2'b00;
      signed_r  <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      data_word <= '0;
      wait_cnt  <= '0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            rw_r      <= cpu_rw;
            size_r    <= cpu_size;
            signed_r  <= cpu_signed;
            addr_r    <= cpu_addr;
            wdata_r   <= cpu_wdata;
            data_word <= cpu_wdata;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_moc || timeout_hit) wait_cnt <= '0;
          else                        wait_cnt <= wait_cnt + CNT_W'(1);
          if (state == RD_WAIT && mem_moc) begin
            data_word <= mem_dataout;
            if (rw_r) cpu_rdata <= extract(mem_dataout, size_r, signed_r, addr_r[1:0]);
          end
        end
        MERGE: data_word <= merge(data_word, wdata_r, size_r, addr_r[1:0]);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_controller.sv
// Bench for mem_bus_controller: handshake RAM responder, directed vector table,
// randomized ops against an array-based reference, timeout and reset sequences.
module tb_mem_bus_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_rw, cpu_signed;
  logic [1:0]  cpu_size;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_busy, cpu_err;
  logic        mem_enable, mem_mov, mem_rw;
  logic [7:0]  mem_address;
  logic [31:0] mem_datain, mem_dataout;
  logic        mem_moc;

  int tests = 0;
  int fails = 0;

  mem_bus_controller #(.TIMEOUT(16), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_size(cpu_size), .cpu_signed(cpu_signed),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_busy(cpu_busy), .cpu_err(cpu_err),
    .mem_enable(mem_enable), .mem_mov(mem_mov), .mem_rw(mem_rw),
    .mem_address(mem_address), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .mem_moc(mem_moc)
  );

  always #5 clk = ~clk;

  // RAM model state, shared between the responder and the main sequence.
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  int  moc_delay = 0;
  bit  mute = 1'b0;
  bit  inject = 1'b0;
  int  rd_txn = 0, wr_txn = 0, en_cycles = 0, mov_cycles = 0, proto_bad = 0;

  // Responder: answers MOV after moc_delay extra cycles and holds MOC until MOV drops.
  initial begin
    int          rcnt;
    logic        prev_mov, prev_en, prev_rw;
    logic [7:0]  prev_addr;
    logic [31:0] prev_data;
    rcnt = 0; prev_mov = 0; prev_en = 0; prev_rw = 0; prev_addr = 0; prev_data = 0;
    mem_moc = 1'b0;
    mem_dataout = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_enable) en_cycles++;
      if (mem_mov) mov_cycles++;
      if (mem_mov && !prev_mov) begin
        if (!prev_en || prev_addr != mem_address || prev_rw != mem_rw || prev_data != mem_datain)
          proto_bad++;
        if (mem_rw) rd_txn++;
        else        wr_txn++;
        rcnt = 0;
      end else if (mem_mov && (prev_addr != mem_address || prev_rw != mem_rw || prev_data != mem_datain)) begin
        proto_bad++;
      end
      if (mute) mem_moc = inject;
      else if (!mem_mov) mem_moc = 1'b0;
      else if (!mem_moc) begin
        if (rcnt == moc_delay) begin
          if (!mem_rw) ram[mem_address] = mem_datain;
          mem_dataout = ram[mem_address];
          mem_moc = 1'b1;
        end else begin
          rcnt++;
        end
      end
      prev_mov = mem_mov; prev_en = mem_enable; prev_rw = mem_rw;
      prev_addr = mem_address; prev_data = mem_datain;
    end
  end

  // Reference rules written straight from the byte-lane definition.
  function automatic logic [31:0] ref_extract(input logic [31:0] w, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] off);
    logic [31:0] v;
    int sh;
    if (size == 2'b10) return w;
    if (size == 2'b00) begin
      sh = 8 * (3 - int'(off));
      v = (w >> sh) & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      sh = off[1] ? 0 : 16;
      v = (w >> sh) & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [1:0] size, input logic [1:0] off);
    logic [31:0] mask;
    int sh;
    if (size == 2'b10) return wd;
    sh   = (size == 2'b00) ? 8 * (3 - int'(off)) : (off[1] ? 0 : 16);
    mask = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] size, input logic [9:0] addr);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 0);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issues one request and waits (bounded) for the ready pulse; lat=999 means no completion.
  task automatic applyStimulus(input logic rw, input logic [1:0] size, input logic sgn,
                               input logic [9:0] addr, input logic [31:0] wd, input bit hold_req,
                               output logic [31:0] rdata, output logic err, output int lat,
                               output int txn, output int en, output bit busy_ok);
    int r0, w0, e0;
    @(negedge clk);
    r0 = rd_txn; w0 = wr_txn; e0 = en_cycles;
    cpu_req = 1'b1; cpu_rw = rw; cpu_size = size; cpu_signed = sgn;
    cpu_addr = addr; cpu_wdata = wd;
    lat = 0; busy_ok = 1'b1; rdata = 'x; err = 1'bx;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (!hold_req) cpu_req = 1'b0;
      if (!cpu_busy) busy_ok = 1'b0;
      if (cpu_ready) begin
        rdata = cpu_rdata;
        err   = cpu_err;
        break;
      end
    end
    cpu_req = 1'b0;
    if (!cpu_ready) lat = 999;
    txn = (rd_txn - r0) * 16 + (wr_txn - w0);
    en  = en_cycles - e0;
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [9:0]  addr;
    logic [31:0] wdata;
    bit          chk_rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_txn;
  } vec_t;

  function automatic vec_t mk(input logic rw, input logic [1:0] size, input logic sgn,
                              input logic [9:0] addr, input logic [31:0] wd, input bit chk,
                              input logic [31:0] rd, input logic err, input int lat, input int txn);
    vec_t v;
    v.rw = rw; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wd;
    v.chk_rdata = chk; v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat; v.exp_txn = txn;
    return v;
  endfunction

  initial begin
    vec_t        vecs[15];
    logic [31:0] rdata, exp_rd, last_rdata;
    logic        err;
    int          lat, txn, en, exp_lat, mov0, bad;
    bit          busy_ok, any_ready, mis;

    vecs[0]  = mk(0, 2'b10, 0, 10'h010, 32'hDEADBEEF, 0, 0,            0, 3, 1);
    vecs[1]  = mk(1, 2'b10, 0, 10'h010, 0,            1, 32'hDEADBEEF, 0, 3, 16);
    vecs[2]  = mk(0, 2'b10, 0, 10'h010, 32'h11223344, 0, 0,            0, 3, 1);
    vecs[3]  = mk(0, 2'b00, 0, 10'h011, 32'h000000AA, 0, 0,            0, 6, 17);
    vecs[4]  = mk(1, 2'b10, 0, 10'h010, 0,            1, 32'h11AA3344, 0, 3, 16);
    vecs[5]  = mk(0, 2'b10, 0, 10'h010, 32'h80FF7F01, 0, 0,            0, 3, 1);
    vecs[6]  = mk(1, 2'b00, 1, 10'h010, 0,            1, 32'hFFFFFF80, 0, 3, 16);
    vecs[7]  = mk(1, 2'b01, 0, 10'h012, 0,            1, 32'h00007F01, 0, 3, 16);
    vecs[8]  = mk(1, 2'b01, 1, 10'h010, 0,            1, 32'hFFFF80FF, 0, 3, 16);
    vecs[9]  = mk(1, 2'b10, 0, 10'h013, 0,            1, 32'hFFFF80FF, 1, 1, 0);
    vecs[10] = mk(1, 2'b01, 0, 10'h011, 0,            1, 32'hFFFF80FF, 1, 1, 0);
    vecs[11] = mk(1, 2'b11, 0, 10'h010, 0,            1, 32'hFFFF80FF, 1, 1, 0);
    vecs[12] = mk(0, 2'b01, 0, 10'h012, 32'hCAFE1234, 0, 0,            0, 6, 17);
    vecs[13] = mk(1, 2'b00, 0, 10'h013, 0,            1, 32'h00000034, 0, 3, 16);
    vecs[14] = mk(1, 2'b00, 1, 10'h011, 0,            1, 32'hFFFFFFFF, 0, 3, 16);

    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end

    reset = 1'b1; cpu_req = 0; cpu_rw = 0; cpu_size = 0; cpu_signed = 0; cpu_addr = 0; cpu_wdata = 0;
    #2;
    checkOutput("reset_rdata", cpu_rdata, 0);
    checkOutput("reset_ctrl", {cpu_ready, cpu_busy, cpu_err, mem_enable, mem_mov, mem_rw}, 0);
    checkOutput("reset_bus", {mem_address, mem_datain}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed table, MOC answered in the first WAIT cycle.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rw, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, 0,
                    rdata, err, lat, txn, en, busy_ok);
      checkOutput($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      checkOutput($sformatf("vec%0d_txn", i), txn, vecs[i].exp_txn);
      checkOutput($sformatf("vec%0d_busy", i), busy_ok, 1);
      if (vecs[i].chk_rdata) checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_err) checkOutput($sformatf("vec%0d_no_enable", i), en, 0);
      if (!vecs[i].rw && !vecs[i].exp_err)
        ref_mem[vecs[i].addr[9:2]] = ref_store(ref_mem[vecs[i].addr[9:2]], vecs[i].wdata,
                                               vecs[i].size, vecs[i].addr[1:0]);
    end
    checkOutput("table_word4", ram[4], 32'h80FF1234);
    last_rdata = 32'hFFFFFFFF;

    // Randomized ops with random MOC delay against the array reference.
    for (int i = 0; i < 40; i++) begin
      logic        rw, sgn;
      logic [1:0]  size;
      logic [9:0]  addr;
      logic [31:0] wd;
      int          d;
      rw = 1'($urandom); sgn = 1'($urandom); size = 2'($urandom);
      addr = 10'($urandom_range(0, 63)); wd = $urandom; d = $urandom_range(0, 3);
      moc_delay = d;
      applyStimulus(rw, size, sgn, addr, wd, 0, rdata, err, lat, txn, en, busy_ok);
      mis = ref_misaligned(size, addr);
      if (mis) begin
        exp_lat = 1; exp_rd = last_rdata;
        checkOutput($sformatf("rnd%0d_txn", i), txn, 0);
      end else if (rw) begin
        exp_lat = 3 + d;
        exp_rd = ref_extract(ref_mem[addr[9:2]], size, sgn, addr[1:0]);
        last_rdata = exp_rd;
      end else begin
        exp_lat = (size == 2'b10) ? 3 + d : 6 + 2 * d;
        exp_rd = last_rdata;
        ref_mem[addr[9:2]] = ref_store(ref_mem[addr[9:2]], wd, size, addr[1:0]);
      end
      checkOutput($sformatf("rnd%0d_err", i), err, mis);
      checkOutput($sformatf("rnd%0d_latency", i), lat, exp_lat);
      checkOutput($sformatf("rnd%0d_rdata", i), rdata, exp_rd);
    end
    moc_delay = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
    checkOutput("ram_vs_reference", bad, 0);

    // MOC never arrives: abort after 16 WAIT cycles, then a stray MOC must do nothing.
    mute = 1'b1;
    mov0 = mov_cycles;
    applyStimulus(1, 2'b10, 0, 10'h020, 0, 0, rdata, err, lat, txn, en, busy_ok);
    checkOutput("timeout_err", err, 1);
    checkOutput("timeout_latency", lat, 18);
    checkOutput("timeout_mov_cycles", mov_cycles - mov0, 16);
    checkOutput("timeout_rdata_held", rdata, last_rdata);
    any_ready = 1'b0;
    @(negedge clk);
    inject = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ready || cpu_busy || mem_mov) any_ready = 1'b1;
    end
    inject = 1'b0;
    mute = 1'b0;
    checkOutput("late_moc_ignored", any_ready, 0);
    applyStimulus(1, 2'b10, 0, 10'h020, 0, 0, rdata, err, lat, txn, en, busy_ok);
    checkOutput("after_timeout_err", err, 0);
    checkOutput("after_timeout_latency", lat, 3);
    checkOutput("after_timeout_rdata", rdata, ref_mem[8]);

    // Reset while the write is waiting for MOC.
    mute = 1'b1;
    @(negedge clk);
    cpu_req = 1; cpu_rw = 0; cpu_size = 2'b10; cpu_signed = 0; cpu_addr = 10'h030; cpu_wdata = 32'h12345678;
    @(negedge clk);
    cpu_req = 0;
    @(negedge clk);
    checkOutput("pre_reset_in_write_wait", {mem_mov, mem_rw, cpu_busy}, 3'b101);
    reset = 1'b1;
    #1;
    checkOutput("midop_reset_ctrl", {cpu_ready, cpu_busy, cpu_err, mem_enable, mem_mov, mem_rw}, 0);
    checkOutput("midop_reset_bus", {mem_address, mem_datain}, 0);
    checkOutput("midop_reset_rdata", cpu_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    mute = 1'b0;

    // Request held high across a whole op must not start a second transaction.
    moc_delay = 2;
    applyStimulus(1, 2'b10, 0, 10'h024, 0, 1, rdata, err, lat, txn, en, busy_ok);
    checkOutput("held_req_latency", lat, 5);
    checkOutput("held_req_rdata", rdata, ref_mem[9]);
    txn = rd_txn + wr_txn;
    repeat (4) @(negedge clk);
    checkOutput("held_req_not_queued", {cpu_busy, 32'(rd_txn + wr_txn - txn)}, 0);
    checkOutput("protocol_setup_hold", proto_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_controller.md
Name: mem_bus_controller

Overview:
- Sequencer between the CPU load/store path and the word-wide asynchronous-handshake data RAM.
- Accepts byte, halfword and word requests, then drives Enable/MOV/RW/Address/DataIn toward the RAM and waits for MOC.
- Performs read-modify-write for sub-word stores, extracts and extends sub-word loads, and flags misalignment and MOC timeout.

Parameters:
TIMEOUT, 16, max clk cycles spent in a WAIT state before abort (must be >=2)
ADDR_W, 10, CPU byte-address width; RAM word address = cpu_addr[ADDR_W-1:2]

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  request strobe, sampled only in IDLE
cpu_rw  in  1  1 = load, 0 = store
cpu_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
cpu_signed  in  1  sign-extend sub-word load when 1
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  32  store data, right-justified for sub-word
cpu_rdata  out  32  load result, valid while cpu_ready=1 and held afterwards
cpu_ready  out  1  one-cycle completion pulse
cpu_busy  out  1  high from the cycle after acceptance through DONE/ERR
cpu_err  out  1  one-cycle pulse, coincident with cpu_ready, on misalignment or timeout
mem_enable  out  1  RAM Enable
mem_mov  out  1  RAM MOV
mem_rw  out  1  RAM RW (1 read, 0 write)
mem_address  out  8  RAM word address
mem_datain  out  32  RAM DataIn
mem_dataout  in  32  RAM DataOut
mem_moc  in  1  RAM MOC, sampled synchronously; the memory holds it high for >=1 clk

Behaviour:
- Reset: all outputs 0; FSM = IDLE; timeout counter = 0; internal request registers = 0.
- Byte order is big-endian: byte 0 = bits 31:24, halfword 0 = bits 31:16.
- States: IDLE, RD_SETUP, RD_WAIT, MERGE, WR_SETUP, WR_WAIT, DONE, ERR.
- IDLE:
  - On cpu_req=1, latch rw/size/signed/addr/wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=11): go to ERR. No RAM access is issued.
  - Otherwise go to RD_SETUP (load, or sub-word store) or WR_SETUP (word store).
- SETUP states: drive mem_enable=1, mem_address, mem_rw, mem_datain with mem_mov=0. Next cycle enter the WAIT state.
- Setup rule: address, rw and data are stable for >=1 clk before mem_mov rises, and stay stable until mem_mov falls.
- WAIT states: mem_mov=1; the counter increments each cycle.
  - mem_moc sampled 1: drop mem_mov, clear the counter.
  - RD_WAIT exit: capture mem_dataout, then go to DONE (load) or MERGE (sub-word store).
  - WR_WAIT exit: go to DONE.
  - Counter reaches TIMEOUT without MOC: drop mem_mov and go to ERR.
- MERGE: mem_mov=0. Replace the addressed byte/half of the captured word with cpu_wdata low bits, then go to WR_SETUP. This guarantees a MOV low period between the read and write phases.
- DONE: cpu_ready=1 for one cycle; mem_enable=0. For loads, cpu_rdata = word, or extracted byte/half zero- or sign-extended per cpu_signed. Next state is IDLE.
- ERR: cpu_ready=1 and cpu_err=1 for one cycle; cpu_rdata unchanged; mem_enable=0. Next state is IDLE.
- Latency:
  - Word load/store with MOC on the first WAIT cycle: accept at edge 0, ready high in cycle 3.
  - Sub-word store: two RAM transactions plus MERGE, ready at cycle 6 best case.
  - Misaligned: ready/err in cycle 1.
- cpu_req while busy, or in DONE/ERR, is ignored; it is not queued.
- mem_moc outside the WAIT states (e.g. a late MOC after timeout) is ignored.
- Reset mid-operation: outputs return to reset values immediately and mem_mov drops. Whether an in-flight RAM write completes is unspecified.

Test Plan:
- Word store 0xDEADBEEF to addr 0x010, then word load from addr 0x010, MOC after 1 cycle each -> RAM word 4 = 0xDEADBEEF; load returns cpu_rdata=0xDEADBEEF; ready at cycle 3 of each op; err=0.
- Word 4 = 0x11223344; byte store 0xAA to addr 0x011 -> a read then a write are issued; mem_mov low >=1 clk between them; word 4 = 0x11AA3344; ready at cycle 6.
- Word 4 = 0x80FF7F01; signed byte load addr 0x010 -> 0xFFFFFF80; unsigned halfword load addr 0x012 -> 0x00007F01; signed halfword load addr 0x010 -> 0xFFFF80FF.
- Word load at addr 0x013, and halfword load at addr 0x011 -> cpu_err and cpu_ready pulse in cycle 1; mem_enable and mem_mov stay 0 throughout.
- Hold mem_moc=0 with TIMEOUT=16 -> mem_mov falls after 16 WAIT cycles, err pulse follows; a later MOC pulse is ignored; the next request completes normally.
- Assert reset while in WR_WAIT -> all outputs 0 immediately, FSM in IDLE; cpu_req pulsed while busy is never serviced.
